// File: rtl/idu_issue_ctrl.sv
// Issue control between the instruction buffer and the decode/issue pipe register.
// Handles flush blocking, serializing-instruction drain, and stall/flush counters.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// RUN       | normal issue; dequeue head whenever avail and downstream ready
// FLUSH     | reads blocked for FLUSH_CYCLES cycles after a redirect
// SER_WAIT  | serializing head waits for the backend to empty
// SER_DRAIN | serializing instruction issued; wait >=2 cycles and rob_empty
module idu_issue_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic                 ibuffer_instr_valid,
    input  logic                 dec_is_serial,
    input  logic                 rob_empty,
    input  logic                 isu_instr_ready,
    input  logic                 flush_valid,
    output logic                 ibuffer_read_en,
    output logic                 issue_valid,
    output logic [1:0]           ctrl_state,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_SER_WAIT  = 2'd2,
        ST_SER_DRAIN = 2'd3
    } state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_e               state_q, state_d;
    logic [3:0]           fcnt_q, fcnt_d;
    logic                 drain_q, drain_d;
    logic [CNT_WIDTH-1:0] stall_q, flush_q;
    logic                 avail, ser_go, read_d, stall_inc;

    assign avail  = ibuffer_instr_valid & ~fifo_empty;
    assign ser_go = avail & dec_is_serial & rob_empty & isu_instr_ready;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        drain_d = drain_q;
        read_d  = 1'b0;
        if (flush_valid) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_LOAD;
            drain_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (avail && dec_is_serial) begin
                        if (ser_go) begin
                            read_d  = 1'b1;
                            state_d = ST_SER_DRAIN;
                            drain_d = 1'b0;
                        end else if (!rob_empty) begin
                            state_d = ST_SER_WAIT;
                        end
                    end else if (avail && isu_instr_ready) begin
                        read_d = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    fcnt_d = fcnt_q - 4'd1;
                    if (fcnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_SER_WAIT: begin
                    if (ser_go) begin
                        read_d  = 1'b1;
                        state_d = ST_SER_DRAIN;
                        drain_d = 1'b0;
                    end
                end
                ST_SER_DRAIN: begin
                    // drain_q marks that the first drain cycle has already passed
                    drain_d = 1'b1;
                    if (drain_q && rob_empty) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign ibuffer_read_en = read_d & ~reset;
    assign issue_valid     = ibuffer_read_en;
    assign stall_inc       = avail & ~read_d & ~flush_valid & (state_q != ST_FLUSH);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            fcnt_q  <= 4'd0;
            drain_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            drain_q <= drain_d;
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_valid && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign ctrl_state = state_q;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_idu_issue_ctrl.sv
// Bench for idu_issue_ctrl: directed scenarios plus a long random run against
// a behavioural model of the issue rules (blocked-cycle budget, drain length).
module tb_idu_issue_ctrl;

    localparam int FC  = 2;
    localparam int CW  = 6;
    localparam int MAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset, fifo_empty, ibuffer_instr_valid, dec_is_serial;
    logic          rob_empty, isu_instr_ready, flush_valid;
    logic          ibuffer_read_en, issue_valid;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // model: 0=RUN 1=FLUSH 2=SER_WAIT 3=SER_DRAIN
    int m_state, m_flush_left, m_drain_n, m_stall, m_fl;
    logic exp_read;

    idu_issue_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clock               (clock),
        .reset               (reset),
        .fifo_empty          (fifo_empty),
        .ibuffer_instr_valid (ibuffer_instr_valid),
        .dec_is_serial       (dec_is_serial),
        .rob_empty           (rob_empty),
        .isu_instr_ready     (isu_instr_ready),
        .flush_valid         (flush_valid),
        .ibuffer_read_en     (ibuffer_read_en),
        .issue_valid         (issue_valid),
        .ctrl_state          (ctrl_state),
        .stall_cnt           (stall_cnt),
        .flush_cnt           (flush_cnt)
    );

    always #5 clock = ~clock;

    // Apply inputs mid-cycle and work out what the model says this cycle.
    task automatic drive(input logic rst, input logic v, input logic e, input logic ser,
                         input logic rob, input logic rdy, input logic fl);
        logic av;
        @(negedge clock);
        reset = rst; ibuffer_instr_valid = v; fifo_empty = e; dec_is_serial = ser;
        rob_empty = rob; isu_instr_ready = rdy; flush_valid = fl;
        #1;
        av = v & ~e;
        exp_read = 1'b0;
        if (!rst && !fl) begin
            if (m_state == 0)
                exp_read = av & rdy & (~ser | rob);
            else if (m_state == 2)
                exp_read = av & ser & rob & rdy;
        end
    endtask

    // Clock edge, then advance the model.
    task automatic tick();
        logic av;
        @(posedge clock);
        av = ibuffer_instr_valid & ~fifo_empty;
        if (reset) begin
            m_state = 0; m_flush_left = 0; m_drain_n = 0; m_stall = 0; m_fl = 0;
        end else begin
            if (av && !exp_read && !flush_valid && m_state != 1 && m_stall < MAX)
                m_stall++;
            if (flush_valid && m_fl < MAX)
                m_fl++;
            if (flush_valid) begin
                m_state = 1;
                m_flush_left = FC;
            end else begin
                case (m_state)
                    0: begin
                        if (exp_read && dec_is_serial) begin
                            m_state = 3; m_drain_n = 0;
                        end else if (av && dec_is_serial && !rob_empty) begin
                            m_state = 2;
                        end
                    end
                    1: begin
                        m_flush_left--;
                        if (m_flush_left == 0) m_state = 0;
                    end
                    2: if (exp_read) begin
                        m_state = 3; m_drain_n = 0;
                    end
                    default: begin
                        m_drain_n++;
                        if (m_drain_n >= 2 && rob_empty) m_state = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic do_reset();
        drive(1, 0, 1, 0, 1, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0, 1, 1, 1);
        checks++;
        if (ibuffer_read_en !== 1'b0 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_read: read=%b issue=%b expected 0 0", ibuffer_read_en, issue_valid);
        end
        tick();
        drive(0, 0, 1, 0, 1, 0, 0);
        checks++;
        if (ctrl_state !== 2'd0 || stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%0d stall=%0d flush=%0d expected 0 0 0",
                     ctrl_state, stall_cnt, flush_cnt);
        end
        tick();
    endtask

    task automatic test_normal_flow();
        int reads = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 1, 1, 0);
            if (ibuffer_read_en === 1'b1 && issue_valid === 1'b1) reads++;
            checks++;
            if (ctrl_state !== 2'd0) begin
                errors++;
                $display("FAIL normal_state: cycle %0d state=%0d expected 0", i, ctrl_state);
            end
            tick();
        end
        drive(0, 0, 1, 0, 1, 1, 0);
        checks++;
        if (reads != 5 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL normal_flow: reads=%0d stall=%0d expected 5 0", reads, stall_cnt);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 1, 0, 0);
            checks++;
            if (ibuffer_read_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_blocked: cycle %0d read=%b expected 0", i, ibuffer_read_en);
            end
            tick();
        end
        drive(0, 1, 0, 0, 1, 1, 0);
        checks++;
        if (ibuffer_read_en !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: read=%b expected 1", ibuffer_read_en);
        end
        tick();
        drive(0, 0, 1, 0, 1, 1, 0);
        checks++;
        if (stall_cnt !== CW'(3)) begin
            errors++;
            $display("FAIL bp_stall_cnt: stall=%0d expected 3", stall_cnt);
        end
        tick();
    endtask

    task automatic test_flush();
        logic exp_r [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 1, 1, (i == 0) ? 1'b1 : 1'b0);
            checks++;
            if (ibuffer_read_en !== exp_r[i]) begin
                errors++;
                $display("FAIL flush_read: t+%0d read=%b expected %b", i, ibuffer_read_en, exp_r[i]);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (ctrl_state !== 2'd1) begin
                    errors++;
                    $display("FAIL flush_state: t+%0d state=%0d expected 1", i, ctrl_state);
                end
            end
            tick();
        end
        drive(0, 0, 1, 0, 1, 1, 0);
        checks++;
        if (flush_cnt !== CW'(1) || stall_cnt !== '0) begin
            errors++;
            $display("FAIL flush_counts: flush=%0d stall=%0d expected 1 0", flush_cnt, stall_cnt);
        end
        tick();
    endtask

    task automatic test_serial();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 1, 0, 1, 0);
            checks++;
            if (ibuffer_read_en !== 1'b0) begin
                errors++;
                $display("FAIL ser_wait_read: cycle %0d read=%b expected 0", i, ibuffer_read_en);
            end
            tick();
        end
        drive(0, 1, 0, 1, 1, 1, 0);
        checks++;
        if (ctrl_state !== 2'd2 || ibuffer_read_en !== 1'b1) begin
            errors++;
            $display("FAIL ser_issue: state=%0d read=%b expected 2 1", ctrl_state, ibuffer_read_en);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, (i == 2) ? 1'b1 : 1'b0, 1, 0);
            checks++;
            if (ctrl_state !== 2'd3 || ibuffer_read_en !== 1'b0) begin
                errors++;
                $display("FAIL ser_drain: cycle %0d state=%0d read=%b expected 3 0",
                         i, ctrl_state, ibuffer_read_en);
            end
            tick();
        end
        drive(0, 1, 0, 0, 1, 1, 0);
        checks++;
        if (ctrl_state !== 2'd0 || ibuffer_read_en !== 1'b1 || stall_cnt !== CW'(7)) begin
            errors++;
            $display("FAIL ser_return: state=%0d read=%b stall=%0d expected 0 1 7",
                     ctrl_state, ibuffer_read_en, stall_cnt);
        end
        tick();
    endtask

    task automatic test_flush_ser_wait();
        do_reset();
        drive(0, 1, 0, 1, 0, 1, 0);
        tick();
        drive(0, 1, 0, 1, 1, 1, 1);
        checks++;
        if (ctrl_state !== 2'd2 || ibuffer_read_en !== 1'b0) begin
            errors++;
            $display("FAIL fsw_flush: state=%0d read=%b expected 2 0", ctrl_state, ibuffer_read_en);
        end
        tick();
        for (int i = 0; i < FC; i++) begin
            drive(0, 1, 0, 1, 1, 1, 0);
            checks++;
            if (ctrl_state !== 2'd1 || ibuffer_read_en !== 1'b0) begin
                errors++;
                $display("FAIL fsw_blocked: cycle %0d state=%0d read=%b expected 1 0",
                         i, ctrl_state, ibuffer_read_en);
            end
            tick();
        end
        drive(0, 1, 0, 0, 1, 1, 0);
        checks++;
        if (ctrl_state !== 2'd0 || ibuffer_read_en !== 1'b1) begin
            errors++;
            $display("FAIL fsw_resume: state=%0d read=%b expected 0 1", ctrl_state, ibuffer_read_en);
        end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        drive(0, 1, 0, 0, 1, 1, 1);
        tick();
        drive(1, 1, 0, 0, 1, 1, 0);
        checks++;
        if (ctrl_state !== 2'd1 || ibuffer_read_en !== 1'b0) begin
            errors++;
            $display("FAIL rmf_reset_cycle: state=%0d read=%b expected 1 0", ctrl_state, ibuffer_read_en);
        end
        tick();
        drive(0, 1, 0, 0, 1, 1, 0);
        checks++;
        if (ctrl_state !== 2'd0 || stall_cnt !== '0 || flush_cnt !== '0 || ibuffer_read_en !== 1'b1) begin
            errors++;
            $display("FAIL rmf_after: state=%0d stall=%0d flush=%0d read=%b expected 0 0 0 1",
                     ctrl_state, stall_cnt, flush_cnt, ibuffer_read_en);
        end
        tick();
    endtask

    task automatic test_random();
        logic rst, v, e, ser, rob, rdy, fl;
        bit   saw_sat = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst = (i > 2500) && ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 9) < 8);
            e   = ($urandom_range(0, 9) == 0);
            ser = ($urandom_range(0, 9) < 2);
            rob = ($urandom_range(0, 9) < 5);
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 99) < 8);
            drive(rst, v, e, ser, rob, rdy, fl);
            checks++;
            if (ibuffer_read_en !== exp_read || issue_valid !== exp_read ||
                ctrl_state !== 2'(m_state)) begin
                errors++;
                $display("FAIL rand_ctrl: cycle %0d read=%b issue=%b state=%0d expected read=%b state=%0d",
                         i, ibuffer_read_en, issue_valid, ctrl_state, exp_read, m_state);
            end
            checks++;
            if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_fl)) begin
                errors++;
                $display("FAIL rand_counts: cycle %0d stall=%0d flush=%0d expected %0d %0d",
                         i, stall_cnt, flush_cnt, m_stall, m_fl);
            end
            if (m_fl == MAX && m_stall == MAX) saw_sat = 1;
            tick();
        end
        checks++;
        if (!saw_sat) begin
            errors++;
            $display("FAIL rand_saturation: both counters at %0d never observed", MAX);
        end
    endtask

    initial begin
        reset = 1'b1; fifo_empty = 1'b1; ibuffer_instr_valid = 1'b0; dec_is_serial = 1'b0;
        rob_empty = 1'b1; isu_instr_ready = 1'b0; flush_valid = 1'b0;
        m_state = 0; m_flush_left = 0; m_drain_n = 0; m_stall = 0; m_fl = 0; exp_read = 1'b0;
        test_reset();
        test_normal_flow();
        test_backpressure();
        test_flush();
        test_serial();
        test_flush_ser_wait();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
